// File: rtl/race_controller.sv
// Race sequencer for the lap timing path: runs the 3-2-1 start countdown,
// strobes the lap timer (start / stop / lap_finished), counts accepted laps
// and ends the race once the configured number of laps has been completed.
module race_controller #(
    parameter int COUNTDOWN_STEP = 65000000,
    parameter int NUM_LAPS       = 3,
    parameter int MIN_LAP_CYCLES = 325000000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       abort_btn,
    input  logic       finish_line,
    input  logic       checkpoint,
    output logic       timer_start,
    output logic       timer_stop,
    output logic       lap_finished,
    output logic [1:0] countdown,
    output logic [3:0] lap_count,
    output logic       race_active,
    output logic       race_done
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN = 2'd1;
    localparam logic [1:0] ST_RACING    = 2'd2;
    localparam logic [1:0] ST_FINISHED  = 2'd3;

    localparam logic [31:0] STEP_LAST   = 32'(COUNTDOWN_STEP - 1);
    localparam logic [31:0] MIN_LAP     = 32'(MIN_LAP_CYCLES);
    localparam logic [3:0]  LAPS_TARGET = 4'(NUM_LAPS);

    logic [1:0]  state_q, state_d;
    logic        startPrev_q, abortPrev_q, finishPrev_q, checkpointPrev_q;
    logic [31:0] step_q, step_d;
    logic [31:0] lapTimer_q, lapTimer_d;
    logic        armed_q, armed_d;
    logic [1:0]  countdown_q, countdown_d;
    logic [3:0]  lapCount_q, lapCount_d;
    logic        raceActive_q, raceActive_d;
    logic        raceDone_q, raceDone_d;
    logic        timerStart_q, timerStart_d;
    logic        timerStop_q, timerStop_d;
    logic        lapFinished_q, lapFinished_d;

    logic startEdge, abortEdge, finishEdge, checkpointEdge;
    logic lapValid;

    assign startEdge      = start_btn   & ~startPrev_q;
    assign abortEdge      = abort_btn   & ~abortPrev_q;
    assign finishEdge     = finish_line & ~finishPrev_q;
    assign checkpointEdge = checkpoint  & ~checkpointPrev_q;

    // A lap counts only with the checkpoint already seen and the minimum lap time served
    assign lapValid = finishEdge & armed_q & (lapTimer_q == MIN_LAP);

    // Registered copies of the inputs so that a held level yields a single edge
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            startPrev_q      <= 1'b0;
            abortPrev_q      <= 1'b0;
            finishPrev_q     <= 1'b0;
            checkpointPrev_q <= 1'b0;
        end else begin
            startPrev_q      <= start_btn;
            abortPrev_q      <= abort_btn;
            finishPrev_q     <= finish_line;
            checkpointPrev_q <= checkpoint;
        end
    end

    // Next-state logic; strobes default low so they can never last beyond one cycle
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        lapTimer_d    = lapTimer_q;
        armed_d       = armed_q;
        countdown_d   = countdown_q;
        lapCount_d    = lapCount_q;
        raceActive_d  = raceActive_q;
        raceDone_d    = raceDone_q;
        timerStart_d  = 1'b0;
        timerStop_d   = 1'b0;
        lapFinished_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISHED: begin
                if (startEdge) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = 2'd3;
                    step_d      = 32'd0;
                    lapCount_d  = 4'd0;
                    raceDone_d  = 1'b0;
                end
            end

            ST_COUNTDOWN: begin
                if (abortEdge) begin
                    state_d     = ST_IDLE;
                    countdown_d = 2'd0;
                    step_d      = 32'd0;
                end else if (step_q == STEP_LAST) begin
                    step_d = 32'd0;
                    if (countdown_q == 2'd1) begin
                        state_d      = ST_RACING;
                        countdown_d  = 2'd0;
                        raceActive_d = 1'b1;
                        timerStart_d = 1'b1;
                        lapTimer_d   = 32'd0;
                        armed_d      = 1'b0;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end else begin
                    step_d = step_q + 32'd1;
                end
            end

            ST_RACING: begin
                if (abortEdge) begin
                    timerStop_d  = 1'b1;
                    state_d      = ST_IDLE;
                    raceActive_d = 1'b0;
                    lapCount_d   = 4'd0;
                    armed_d      = 1'b0;
                    lapTimer_d   = 32'd0;
                end else if (lapValid) begin
                    lapFinished_d = 1'b1;
                    lapCount_d    = lapCount_q + 4'd1;
                    armed_d       = 1'b0;
                    lapTimer_d    = 32'd0;
                    if (lapCount_q + 4'd1 == LAPS_TARGET) begin
                        timerStop_d  = 1'b1;
                        state_d      = ST_FINISHED;
                        raceActive_d = 1'b0;
                        raceDone_d   = 1'b1;
                    end
                end else begin
                    if (lapTimer_q < MIN_LAP) begin
                        lapTimer_d = lapTimer_q + 32'd1;
                    end
                    if (checkpointEdge) begin
                        armed_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= 32'd0;
            lapTimer_q    <= 32'd0;
            armed_q       <= 1'b0;
            countdown_q   <= 2'd0;
            lapCount_q    <= 4'd0;
            raceActive_q  <= 1'b0;
            raceDone_q    <= 1'b0;
            timerStart_q  <= 1'b0;
            timerStop_q   <= 1'b0;
            lapFinished_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            lapTimer_q    <= lapTimer_d;
            armed_q       <= armed_d;
            countdown_q   <= countdown_d;
            lapCount_q    <= lapCount_d;
            raceActive_q  <= raceActive_d;
            raceDone_q    <= raceDone_d;
            timerStart_q  <= timerStart_d;
            timerStop_q   <= timerStop_d;
            lapFinished_q <= lapFinished_d;
        end
    end

    assign timer_start  = timerStart_q;
    assign timer_stop   = timerStop_q;
    assign lap_finished = lapFinished_q;
    assign countdown    = countdown_q;
    assign lap_count    = lapCount_q;
    assign race_active  = raceActive_q;
    assign race_done    = raceDone_q;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: directed race scenarios followed by random input
// traffic, every cycle compared against a timestamp-based race model.
module tb_race_controller;

    localparam int STEP = 4;
    localparam int LAPS = 3;
    localparam int MINL = 20;

    localparam int M_IDLE     = 0;
    localparam int M_COUNT    = 1;
    localparam int M_RACING   = 2;
    localparam int M_FINISHED = 3;

    logic       pclk;
    logic       rst;
    logic       start_btn, abort_btn, finish_line, checkpoint;
    logic       timer_start, timer_stop, lap_finished;
    logic [1:0] countdown;
    logic [3:0] lap_count;
    logic       race_active, race_done;

    int errors = 0;
    int checks = 0;

    // Model state: race phase plus the edge indices at which things happened
    int   cyc;
    int   mMode;
    int   mCdStart;
    int   mLapRef;
    int   mLaps;
    bit   mArmed;
    bit   mStartS, mStopS, mLapS;
    int   mDigit;
    bit   pS, pA, pF, pC;

    // Observed strobe counters
    int nStart = 0;
    int nStop  = 0;
    int nLap   = 0;
    int nBoth  = 0;

    race_controller #(
        .COUNTDOWN_STEP(STEP),
        .NUM_LAPS(LAPS),
        .MIN_LAP_CYCLES(MINL)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .start_btn(start_btn),
        .abort_btn(abort_btn),
        .finish_line(finish_line),
        .checkpoint(checkpoint),
        .timer_start(timer_start),
        .timer_stop(timer_stop),
        .lap_finished(lap_finished),
        .countdown(countdown),
        .lap_count(lap_count),
        .race_active(race_active),
        .race_done(race_done)
    );

    // Free-running pixel clock
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic f, input logic c, input int n);
        start_btn   = s;
        abort_btn   = a;
        finish_line = f;
        checkpoint  = c;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // Reference model: decides each edge from the race rules using elapsed cycle counts
    initial begin
        forever begin
            @(posedge pclk or posedge rst);
            if (rst) begin
                cyc = 0; mMode = M_IDLE; mCdStart = 0; mLapRef = 0; mLaps = 0;
                mArmed = 0; mStartS = 0; mStopS = 0; mLapS = 0; mDigit = 0;
                pS = 0; pA = 0; pF = 0; pC = 0;
            end else begin
                bit eS, eA, eF, eC, accept;
                eS = start_btn && !pS;
                eA = abort_btn && !pA;
                eF = finish_line && !pF;
                eC = checkpoint && !pC;
                pS = start_btn; pA = abort_btn; pF = finish_line; pC = checkpoint;
                mStartS = 0; mStopS = 0; mLapS = 0;
                case (mMode)
                    M_IDLE, M_FINISHED: begin
                        if (eS) begin
                            mMode = M_COUNT;
                            mCdStart = cyc;
                            mLaps = 0;
                        end
                    end
                    M_COUNT: begin
                        if (eA) begin
                            mMode = M_IDLE;
                        end else if (cyc - mCdStart == 3 * STEP) begin
                            mMode = M_RACING;
                            mStartS = 1;
                            mLapRef = cyc;
                            mArmed = 0;
                        end
                    end
                    default: begin
                        // Lap counter value during this cycle is cycles since reset point minus one
                        accept = eF && mArmed && ((cyc - mLapRef - 1) >= MINL);
                        if (eA) begin
                            mStopS = 1;
                            mMode = M_IDLE;
                            mLaps = 0;
                        end else if (accept) begin
                            mLapS = 1;
                            mLaps++;
                            mArmed = 0;
                            mLapRef = cyc;
                            if (mLaps == LAPS) begin
                                mStopS = 1;
                                mMode = M_FINISHED;
                            end
                        end else if (eC) begin
                            mArmed = 1;
                        end
                    end
                endcase
                mDigit = (mMode == M_COUNT) ? 3 - (cyc - mCdStart) / STEP : 0;
                cyc++;
            end
        end
    end

    // Compare every output with the model and tally strobes on the falling edge
    initial begin
        forever begin
            @(negedge pclk);
            checkOutput("timer_start",  32'(timer_start),  32'(mStartS));
            checkOutput("timer_stop",   32'(timer_stop),   32'(mStopS));
            checkOutput("lap_finished", 32'(lap_finished), 32'(mLapS));
            checkOutput("countdown",    32'(countdown),    32'(mDigit));
            checkOutput("lap_count",    32'(lap_count),    32'(mLaps));
            checkOutput("race_active",  32'(race_active),  32'(mMode == M_RACING));
            checkOutput("race_done",    32'(race_done),    32'(mMode == M_FINISHED));
            if (timer_start) nStart++;
            if (timer_stop) nStop++;
            if (lap_finished) nLap++;
            if (timer_stop && lap_finished) nBoth++;
        end
    end

    // Directed scenarios, then random traffic
    initial begin
        int savedStart;
        int savedStop;
        rst = 1'b1;
        start_btn = 0; abort_btn = 0; finish_line = 0; checkpoint = 0;
        #1;
        checkOutput("rst_timer_start", 32'(timer_start), 0);
        checkOutput("rst_timer_stop", 32'(timer_stop), 0);
        checkOutput("rst_lap_finished", 32'(lap_finished), 0);
        checkOutput("rst_countdown", 32'(countdown), 0);
        checkOutput("rst_lap_count", 32'(lap_count), 0);
        checkOutput("rst_race_active", 32'(race_active), 0);
        checkOutput("rst_race_done", 32'(race_done), 0);
        repeat (3) @(posedge pclk);
        #3 rst = 1'b0;
        @(posedge pclk);
        #1;

        $display("[TB] start countdown");
        applyStimulus(1, 0, 0, 0, 1);
        for (int k = 1; k <= 14; k++) begin
            checkOutput("cd_digit", 32'(countdown), (k <= 4) ? 3 : (k <= 8) ? 2 : (k <= 12) ? 1 : 0);
            checkOutput("cd_tstart", 32'(timer_start), 32'(k == 13));
            checkOutput("cd_active", 32'(race_active), 32'(k >= 13));
            applyStimulus(0, 0, 0, 0, 1);
        end

        $display("[TB] full race");
        for (int lap = 1; lap <= 3; lap++) begin
            applyStimulus(0, 0, 0, 1, 1);
            applyStimulus(0, 0, 0, 0, 25);
            applyStimulus(0, 0, 1, 0, 1);
            checkOutput("race_lap_pulse", 32'(lap_finished), 1);
            checkOutput("race_lap_count", 32'(lap_count), 32'(lap));
            checkOutput("race_stop", 32'(timer_stop), 32'(lap == 3));
            applyStimulus(0, 0, 0, 0, 2);
        end
        checkOutput("race_done_hi", 32'(race_done), 1);
        checkOutput("race_active_lo", 32'(race_active), 0);
        checkOutput("race_laps_hold", 32'(lap_count), 3);
        checkOutput("race_n_laps", 32'(nLap), 3);
        checkOutput("race_stop_with_lap", 32'(nBoth), 1);

        $display("[TB] lap rejection and simultaneous events");
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("restart_laps", 32'(lap_count), 0);
        checkOutput("restart_cd", 32'(countdown), 3);
        checkOutput("restart_done", 32'(race_done), 0);
        applyStimulus(0, 0, 0, 0, 12);
        checkOutput("restart_active", 32'(race_active), 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 9);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("early_finish", 32'(lap_finished), 0);
        applyStimulus(0, 0, 0, 0, 15);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("late_finish", 32'(lap_finished), 1);
        checkOutput("late_finish_count", 32'(lap_count), 1);
        applyStimulus(0, 0, 0, 0, 25);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("unarmed_finish", 32'(lap_finished), 0);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("simul_unarmed", 32'(lap_finished), 0);
        applyStimulus(0, 0, 0, 0, 2);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("simul_armed", 32'(lap_finished), 1);
        checkOutput("simul_armed_count", 32'(lap_count), 2);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 25);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("abort_fin_stop", 32'(timer_stop), 1);
        checkOutput("abort_fin_lap", 32'(lap_finished), 0);
        checkOutput("abort_fin_count", 32'(lap_count), 0);
        checkOutput("abort_fin_active", 32'(race_active), 0);
        checkOutput("abort_fin_done", 32'(race_done), 0);
        applyStimulus(0, 0, 0, 0, 2);

        $display("[TB] abort during countdown");
        savedStart = nStart;
        savedStop = nStop;
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 5);
        checkOutput("cd_two", 32'(countdown), 2);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("cd_abort_digit", 32'(countdown), 0);
        applyStimulus(0, 0, 0, 0, 15);
        checkOutput("cd_abort_no_start", 32'(nStart), 32'(savedStart));
        checkOutput("cd_abort_no_stop", 32'(nStop), 32'(savedStop));
        checkOutput("cd_abort_idle", 32'(race_active), 0);

        $display("[TB] async reset mid-race");
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 20);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 3);
        checkOutput("pre_rst_active", 32'(race_active), 1);
        #3 rst = 1'b1;
        #1;
        checkOutput("arst_active", 32'(race_active), 0);
        checkOutput("arst_stop", 32'(timer_stop), 0);
        checkOutput("arst_lap", 32'(lap_finished), 0);
        checkOutput("arst_count", 32'(lap_count), 0);
        checkOutput("arst_cd", 32'(countdown), 0);
        @(posedge pclk);
        @(posedge pclk);
        #3 rst = 1'b0;
        @(posedge pclk);
        #1;
        applyStimulus(0, 0, 0, 0, 4);
        checkOutput("post_rst_active", 32'(race_active), 0);
        checkOutput("post_rst_cd", 32'(countdown), 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 6, $urandom_range(0, 999) < 8,
                          $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Sequences one race for the lap timing path: 3-2-1 start countdown, start/stop/lap_finished strobes to the lap timer, lap counting, race end.
- Sits between the game/input logic (buttons, car-over-line and checkpoint flags) and the lap timer.
- Lap is accepted only if the checkpoint was crossed since the last lap and a minimum lap time has elapsed.

Parameters:
- COUNTDOWN_STEP, 65000000, pclk cycles per countdown digit (1 s at 65 MHz).
- NUM_LAPS, 3, laps per race, 1..15.
- MIN_LAP_CYCLES, 325000000, minimum pclk cycles between race start/previous lap and an accepted lap.

Ports:
- pclk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start_btn  in  1  start request, level, synchronous to pclk.
- abort_btn  in  1  abort request, level, synchronous.
- finish_line  in  1  car over finish line, level, synchronous.
- checkpoint  in  1  car over mid-track checkpoint, level, synchronous.
- timer_start  out  1  one-cycle strobe to lap timer start.
- timer_stop  out  1  one-cycle strobe to lap timer stop.
- lap_finished  out  1  one-cycle strobe to lap timer lap_finished.
- countdown  out  2  digit shown during countdown (3,2,1), else 0.
- lap_count  out  4  completed laps this race.
- race_active  out  1  high in RACING.
- race_done  out  1  high in FINISHED.

Behaviour:
- Reset: state IDLE; all outputs 0; edge-detect regs, armed flag and counters 0.
- Every input is rising-edge detected against a registered copy of itself. All outputs are registered: an edge first sampled at cycle N acts at N+1.
- States: IDLE, COUNTDOWN, RACING, FINISHED.
- IDLE / FINISHED:
  - start_btn edge -> COUNTDOWN; countdown=3; step counter=0; lap_count=0; race_done=0.
  - Other inputs ignored.
- COUNTDOWN:
  - Step counter counts 0..COUNTDOWN_STEP-1, then wraps and decrements countdown.
  - When countdown is 1 and the counter wraps -> RACING; countdown=0; race_active=1; timer_start=1 for exactly that cycle.
  - Lap counter and armed flag are cleared on entry to RACING.
  - Total start latency from the start edge is 3*COUNTDOWN_STEP+1 cycles.
  - abort_btn edge -> IDLE; countdown=0; no strobes.
  - start_btn edges are ignored.
- RACING:
  - Lap counter increments every cycle and saturates at MIN_LAP_CYCLES. It is 32 bits wide.
  - checkpoint edge sets armed.
  - finish_line edge is accepted when armed=1 (value before this cycle's update) and the lap counter is at MIN_LAP_CYCLES.
  - On an accepted finish: lap_finished pulse; lap_count+1; armed=0; lap counter=0. A checkpoint edge in the same cycle is discarded.
  - Rejected finish edges have no effect.
  - If the accepted lap makes lap_count==NUM_LAPS: timer_stop pulse in the same cycle as lap_finished; -> FINISHED; race_active=0; race_done=1.
  - lap_count holds in FINISHED until the next start.
  - abort_btn edge: timer_stop pulse; -> IDLE; race_active=0; lap_count=0.
  - Abort has priority over a simultaneous finish: no lap_finished pulse.
  - start_btn edges are ignored.
- Strobes are never high for more than 1 cycle. Holding an input high produces a single edge.
- Reset asserted mid-race forces IDLE immediately with all outputs 0. No stop strobe is issued, because the lap timer shares rst.

Test Plan:
Bench parameters: COUNTDOWN_STEP=4, NUM_LAPS=3, MIN_LAP_CYCLES=20.
- Start: start_btn rise at cycle 0 -> countdown 3,2,1 each held 4 cycles; timer_start single pulse at cycle 13; race_active=1 from cycle 13.
- Full race: three laps, each with checkpoint then finish ≥20 cycles apart -> lap_finished pulses with lap_count 1,2,3. The third lap pulse coincides with the timer_stop pulse; race_done=1, race_active=0, lap_count stays 3.
- Lap rejection:
  - Finish without checkpoint -> no lap_finished.
  - Checkpoint then finish at 10 cycles -> no lap_finished; armed stays set.
  - A second finish after cycle 20 -> accepted, lap_count=1.
- Simultaneous events:
  - Checkpoint and finish rise in the same cycle with armed=0 -> lap rejected, armed=1.
  - With armed=1 -> lap accepted, armed=0.
  - Abort and a valid finish together -> timer_stop only; state IDLE; lap_count=0.
- Abort and restart: abort during countdown=2 -> IDLE with no strobes. A start from FINISHED -> countdown restarts and lap_count clears to 0.
- Async reset: assert rst mid-RACING between clock edges -> all outputs 0 before the next pclk edge; state IDLE after release.
